// File: rtl/bin2gray_counter_if.sv
// rtl/bin2gray_counter_if.sv - control and count signals of the binary-to-Gray counter
interface bin2gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] gray_next;
  logic             wrap;

  modport master (
    output load, load_bin, en, up,
    input  bin, gray, gray_next, wrap
  );

  modport slave (
    input  load, load_bin, en, up,
    output bin, gray, gray_next, wrap
  );
endinterface

// File: rtl/bin2gray_counter.sv
// rtl/bin2gray_counter.sv - registered binary up/down counter with a registered Gray copy
// The Gray flop is loaded from the encoded next value so it never glitches.
module bin2gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 srstn,
  bin2gray_counter_if.slave    bus
);
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;

  // Reset folds into the next value so gray_next reads 0 while srstn is low.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (!srstn) begin
      w_bin_next = '0;
    end else if (bus.load) begin
      w_bin_next = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        w_bin_next  = r_bin + WIDTH'(1);
        w_wrap_next = &r_bin;
      end else begin
        w_bin_next  = r_bin - WIDTH'(1);
        w_wrap_next = ~|r_bin;
      end
    end
    w_gray_next = w_bin_next ^ (w_bin_next >> 1);
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.bin       = r_bin;
  assign bus.gray      = r_gray;
  assign bus.gray_next = w_gray_next;
  assign bus.wrap      = r_wrap;
endmodule

// File: tb/tb_bin2gray_counter.sv
// tb/tb_bin2gray_counter.sv - directed self-checking bench for bin2gray_counter
module tb_bin2gray_counter;
  logic clk = 1'b0;
  logic srstn;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   gseq [17] = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 'h9, 'h8, 'h0};
  int   prev_g;

  always #5 clk = ~clk;

  bin2gray_counter_if #(.WIDTH(4)) bus ();

  bin2gray_counter #(.WIDTH(4)) dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int b, input int g, input int w);
    chk({tag, ".bin"}, int'(bus.bin), b);
    chk({tag, ".gray"}, int'(bus.gray), g);
    chk({tag, ".wrap"}, int'(bus.wrap), w);
  endtask

  initial begin
    srstn        = 1'b0;
    bus.en       = 1'b1;
    bus.load     = 1'b1;
    bus.load_bin = 4'hA;
    bus.up       = 1'b1;
    #1;
    chk("rst.gray_next0", int'(bus.gray_next), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("rst", 0, 0, 0);
      chk("rst.gray_next", int'(bus.gray_next), 0);
    end

    // full up-count through the wrap
    srstn    = 1'b1;
    bus.load = 1'b0;
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    prev_g   = 0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("up.gray_next", int'(bus.gray_next), gseq[k]);
      tick();
      chk_state("up", k % 16, gseq[k], (k == 16) ? 1 : 0);
      chk("up.onebit", $countones(bus.gray ^ 4'(prev_g)), 1);
      prev_g = int'(bus.gray);
    end

    // down-count across zero
    srstn = 1'b0;
    tick();
    chk_state("dn.rst", 0, 0, 0);
    srstn  = 1'b1;
    bus.up = 1'b0;
    tick();
    chk_state("dn.wrap", 'hF, 'h8, 1);
    tick();
    chk_state("dn.next", 'hE, 'h9, 0);

    // load priority over en
    bus.en       = 1'b0;
    bus.load     = 1'b1;
    bus.load_bin = 4'h3;
    tick();
    chk_state("ld.three", 3, 2, 0);
    bus.load_bin = 4'hA;
    bus.en       = 1'b1;
    bus.up       = 1'b1;
    tick();
    chk_state("ld.prio", 'hA, 'hF, 0);
    bus.load = 1'b0;
    tick();
    chk_state("ld.after", 'hB, 'hE, 0);

    // load across the range never wraps
    bus.load     = 1'b1;
    bus.en       = 1'b0;
    bus.load_bin = 4'hF;
    tick();
    chk_state("ld.f", 'hF, 'h8, 0);
    bus.load_bin = 4'h0;
    tick();
    chk_state("ld.zero", 0, 0, 0);

    // hold and gray_next
    bus.load_bin = 4'h6;
    tick();
    chk_state("hold.load", 6, 5, 0);
    bus.load = 1'b0;
    bus.en   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_state("hold", 6, 5, 0);
      chk("hold.gray_next", int'(bus.gray_next), 5);
    end
    bus.en = 1'b1;
    bus.up = 1'b1;
    #1;
    chk("hold.gn_up", int'(bus.gray_next), 4);
    tick();
    chk_state("hold.step", 7, 4, 0);

    // direction change takes effect immediately
    bus.up = 1'b0;
    tick();
    chk_state("dir.down", 6, 5, 0);

    // reset mid-operation
    bus.load     = 1'b1;
    bus.load_bin = 4'h9;
    tick();
    chk_state("mid.nine", 9, 'hD, 0);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    srstn    = 1'b0;
    #1;
    chk("mid.gray_next", int'(bus.gray_next), 0);
    tick();
    chk_state("mid.rst", 0, 0, 0);
    srstn = 1'b1;
    tick();
    chk_state("mid.one", 1, 1, 0);
    tick();
    chk_state("mid.two", 2, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
